// File: rtl/fifo_pkg.sv
// Shared constants and payload types for the 8x32 channel FIFO and its
// pointer/flag controller.
//   FIFO_DEPTH     entries in the RAM (must equal 2**FIFO_PTR_WIDE)
//   FIFO_PTR_WIDE  RAM address width
//   FIFO_WIDE      RAM data width
//   AFULL_LVL      almost_full threshold (count >= AFULL_LVL)
//   AEMPTY_LVL     almost_empty threshold (count <= AEMPTY_LVL)
package fifo_pkg;

  localparam int unsigned FIFO_DEPTH    = 8;
  localparam int unsigned FIFO_PTR_WIDE = 3;
  localparam int unsigned FIFO_WIDE     = 32;
  localparam int unsigned AFULL_LVL     = 6;
  localparam int unsigned AEMPTY_LVL    = 2;

  // Registered status flags, grouped so they reset/flush as one value.
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  // Sticky error flags.
  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

  localparam fifo_flags_t FLAGS_RST = '{
    full:         1'b0,
    empty:        1'b1,
    almost_full:  1'b0,
    almost_empty: 1'b1
  };

  localparam fifo_err_t ERR_RST = '{overflow: 1'b0, underflow: 1'b0};

endpackage

// File: rtl/fifo_ptr_cnt.sv
// Wrap-bit pointer for one side of the FIFO.
//   clk, rst  clock, async active-high reset
//   clr       synchronous clear to 0 (flush)
//   inc       advance by one (accepted RAM access)
//   ptr       full pointer, MSB is the wrap bit
//   addr      low bits of ptr, drives the RAM address
module fifo_ptr_cnt #(
  parameter int unsigned PTR_WIDE = fifo_pkg::FIFO_PTR_WIDE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                inc,
  output logic [PTR_WIDE:0]   ptr,
  output logic [PTR_WIDE-1:0] addr
);

  localparam int unsigned PW = PTR_WIDE + 1;

  logic [PW-1:0] ptr_q;

  // Natural PW-bit rollover gives the modulo 2*DEPTH wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (clr) begin
      ptr_q <= '0;
    end else if (inc) begin
      ptr_q <= ptr_q + PW'(1);
    end
  end

  assign ptr  = ptr_q;
  assign addr = ptr_q[PTR_WIDE-1:0];

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Pointer/flag controller for the 8x32 channel FIFO RAM.
//   clk, rst        clock, async active-high reset
//   wr_req, rd_req  producer / consumer requests
//   flush           sync clear of pointers and count (errors kept)
//   clr_err         sync clear of sticky overflow/underflow
//   wr_en, rd_en    combinational accepted-access strobes to the RAM
//   wr_addr,rd_addr RAM addresses (low pointer bits)
//   full, empty, almost_full, almost_empty  registered flags
//   count           registered occupancy 0..FIFO_DEPTH
//   rd_valid        RAM data_out valid, one cycle after rd_en
//   overflow        sticky: wr_req while full
//   underflow       sticky: rd_req while empty
module fifo_ptr_ctrl #(
  parameter int unsigned FIFO_DEPTH    = fifo_pkg::FIFO_DEPTH,
  parameter int unsigned FIFO_PTR_WIDE = fifo_pkg::FIFO_PTR_WIDE,
  parameter int unsigned AFULL_LVL     = fifo_pkg::AFULL_LVL,
  parameter int unsigned AEMPTY_LVL    = fifo_pkg::AEMPTY_LVL
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_req,
  input  logic                     rd_req,
  input  logic                     flush,
  input  logic                     clr_err,
  output logic                     wr_en,
  output logic                     rd_en,
  output logic [FIFO_PTR_WIDE-1:0] wr_addr,
  output logic [FIFO_PTR_WIDE-1:0] rd_addr,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [FIFO_PTR_WIDE:0]   count,
  output logic                     rd_valid,
  output logic                     overflow,
  output logic                     underflow
);

  import fifo_pkg::*;

  localparam int unsigned CW = FIFO_PTR_WIDE + 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LVL);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LVL);

  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_nxt;
  fifo_flags_t   flags_q;
  fifo_flags_t   flags_nxt;
  fifo_err_t     err_q;
  fifo_err_t     err_nxt;
  logic          rd_valid_q;

  // Access gating from registered flags; nothing is accepted in reset or flush.
  assign wr_en = ~rst & wr_req & ~flags_q.full  & ~flush;
  assign rd_en = ~rst & rd_req & ~flags_q.empty & ~flush;

  fifo_ptr_cnt #(.PTR_WIDE(FIFO_PTR_WIDE)) u_wr_ptr (
    .clk  (clk),
    .rst  (rst),
    .clr  (flush),
    .inc  (wr_en),
    .ptr  (wr_ptr),
    .addr (wr_addr)
  );

  fifo_ptr_cnt #(.PTR_WIDE(FIFO_PTR_WIDE)) u_rd_ptr (
    .clk  (clk),
    .rst  (rst),
    .clr  (flush),
    .inc  (rd_en),
    .ptr  (rd_ptr),
    .addr (rd_addr)
  );

  // Next occupancy, flags derived from it, and sticky error update.
  always_comb begin
    count_nxt = count_q;
    flags_nxt = flags_q;
    err_nxt   = err_q;

    if (flush) begin
      count_nxt = '0;
    end else begin
      count_nxt = count_q + CW'(wr_en) - CW'(rd_en);
    end

    flags_nxt.full         = (count_nxt == DEPTH_C);
    flags_nxt.empty        = (count_nxt == '0);
    flags_nxt.almost_full  = (count_nxt >= AFULL_C);
    flags_nxt.almost_empty = (count_nxt <= AEMPTY_C);

    // Set wins over clear; requests during flush are ignored entirely.
    err_nxt.overflow  = (wr_req & flags_q.full  & ~flush) | (err_q.overflow  & ~clr_err);
    err_nxt.underflow = (rd_req & flags_q.empty & ~flush) | (err_q.underflow & ~clr_err);
  end

  // Status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      flags_q    <= FLAGS_RST;
      err_q      <= ERR_RST;
      rd_valid_q <= 1'b0;
    end else begin
      count_q    <= count_nxt;
      flags_q    <= flags_nxt;
      err_q      <= err_nxt;
      rd_valid_q <= rd_en;
    end
  end

  assign count        = count_q;
  assign full         = flags_q.full;
  assign empty        = flags_q.empty;
  assign almost_full  = flags_q.almost_full;
  assign almost_empty = flags_q.almost_empty;
  assign overflow     = err_q.overflow;
  assign underflow    = err_q.underflow;
  assign rd_valid     = rd_valid_q;

  // Flags are mutually exclusive; occupancy tracks the pointer distance.
  a_full_empty_excl: assert property (@(posedge clk) disable iff (rst)
    !(flags_q.full && flags_q.empty));

  a_count_matches_ptrs: assert property (@(posedge clk) disable iff (rst)
    count_q == CW'(wr_ptr - rd_ptr));

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
module tb_fifo_ptr_ctrl;

  import fifo_pkg::*;

  localparam int unsigned PW   = FIFO_PTR_WIDE;
  localparam int unsigned CW   = FIFO_PTR_WIDE + 1;
  localparam int          DEP  = int'(FIFO_DEPTH);
  localparam int          PMOD = 2 * int'(FIFO_DEPTH);

  logic          clk;
  logic          rst;
  logic          wr_req, rd_req, flush, clr_err;
  logic          wr_en, rd_en;
  logic [PW-1:0] wr_addr, rd_addr;
  logic          full, empty, almost_full, almost_empty;
  logic [CW-1:0] count;
  logic          rd_valid, overflow, underflow;

  int checks;
  int errors;

  // Behavioural RAM driven by the DUT strobes, plus the read-data scoreboard.
  logic [FIFO_WIDE-1:0] mem [FIFO_DEPTH];
  logic [FIFO_WIDE-1:0] wdata;
  logic [FIFO_WIDE-1:0] rdata;
  logic [FIFO_WIDE-1:0] exp_q [$];

  // Reference model state.
  int   m_count, m_wp, m_rp;
  logic m_ovf, m_udf;
  logic exp_wen, exp_ren;
  logic cur_w, cur_r, cur_f, cur_c;

  fifo_ptr_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .wr_req       (wr_req),
    .rd_req       (rd_req),
    .flush        (flush),
    .clr_err      (clr_err),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .wr_addr      (wr_addr),
    .rd_addr      (rd_addr),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .rd_valid     (rd_valid),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wdata;
    if (rd_en) rdata <= mem[rd_addr];
  end

  task automatic model_reset();
    m_count = 0; m_wp = 0; m_rp = 0;
    m_ovf = 1'b0; m_udf = 1'b0;
    exp_q.delete();
  endtask

  // Drive one cycle's requests at posedge+1 and let combinational strobes settle.
  task automatic set_in(input logic w, input logic r, input logic f, input logic c);
    cur_w = w; cur_r = r; cur_f = f; cur_c = c;
    wr_req = w; rd_req = r; flush = f; clr_err = c;
    wdata = $urandom;
    exp_wen = w && (m_count < DEP) && !f;
    exp_ren = r && (m_count > 0) && !f;
    #1;
  endtask

  // Advance the model and the clock; drain the read-data scoreboard.
  task automatic tick();
    logic [FIFO_WIDE-1:0] exp_d;
    int old;
    old   = m_count;
    m_ovf = (cur_w && old == DEP && !cur_f) || (m_ovf && !cur_c);
    m_udf = (cur_r && old == 0 && !cur_f) || (m_udf && !cur_c);
    if (cur_f) begin
      m_count = 0; m_wp = 0; m_rp = 0;
      exp_q.delete();
    end else begin
      if (exp_wen) begin
        exp_q.push_back(wdata);
        m_wp = (m_wp + 1) % PMOD;
        m_count++;
      end
      if (exp_ren) begin
        m_rp = (m_rp + 1) % PMOD;
        m_count--;
      end
    end
    @(posedge clk); #1;
    if (rd_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL rd_data: rd_valid with no expected entry, got %h", rdata);
      end else begin
        exp_d = exp_q.pop_front();
        if (rdata !== exp_d) begin
          errors++; $display("FAIL rd_data: got %h expected %h", rdata, exp_d);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_req = 1'b1; rd_req = 1'b1; flush = 1'b0; clr_err = 1'b0; wdata = '0;
    #1;
    checks++; if (count !== '0) begin errors++; $display("FAIL rst_count: got %0d expected 0", count); end
    checks++; if ({full, empty, almost_full, almost_empty} !== 4'b0101) begin
      errors++; $display("FAIL rst_flags: got %b expected 0101", {full, empty, almost_full, almost_empty});
    end
    checks++; if ({rd_valid, overflow, underflow} !== 3'b000) begin
      errors++; $display("FAIL rst_status: got %b expected 000", {rd_valid, overflow, underflow});
    end
    checks++; if ({wr_en, rd_en} !== 2'b00) begin
      errors++; $display("FAIL rst_strobes: got %b expected 00", {wr_en, rd_en});
    end
    checks++; if ({wr_addr, rd_addr} !== '0) begin
      errors++; $display("FAIL rst_addr: got %0d/%0d expected 0/0", wr_addr, rd_addr);
    end
    @(posedge clk); #1;
    rst = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    model_reset();
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEP; i++) begin
      set_in(1'b1, 1'b0, 1'b0, 1'b0);
      checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL fill_wr_en: got %b expected 1 (write %0d)", wr_en, i); end
      tick();
      checks++; if (count !== CW'(i)) begin errors++; $display("FAIL fill_count: got %0d expected %0d", count, i); end
      checks++; if (almost_full !== (i >= 6)) begin errors++; $display("FAIL fill_afull: got %b expected %b at %0d", almost_full, (i >= 6), i); end
      checks++; if (full !== (i == DEP)) begin errors++; $display("FAIL fill_full: got %b expected %b at %0d", full, (i == DEP), i); end
      checks++; if (empty !== 1'b0) begin errors++; $display("FAIL fill_empty: got %b expected 0 at %0d", empty, i); end
    end
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL ovf_wr_en: got %b expected 0", wr_en); end
    tick();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    checks++; if (count !== CW'(8)) begin errors++; $display("FAIL ovf_count: got %0d expected 8", count); end
  endtask

  task automatic test_full_rw();
    set_in(1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if ({wr_en, rd_en} !== 2'b01) begin errors++; $display("FAIL full_rw_strobes: got %b expected 01", {wr_en, rd_en}); end
    tick();
    checks++; if (count !== CW'(7)) begin errors++; $display("FAIL full_rw_count: got %0d expected 7", count); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_rw_full: got %b expected 0", full); end
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL full_rw_rd_valid: got %b expected 1", rd_valid); end
  endtask

  task automatic test_drain_empty_rw();
    for (int i = 6; i >= 0; i--) begin
      set_in(1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      checks++; if (count !== CW'(i)) begin errors++; $display("FAIL drain_count: got %0d expected %0d", count, i); end
      checks++; if (almost_empty !== (i <= 2)) begin errors++; $display("FAIL drain_aempty: got %b expected %b at %0d", almost_empty, (i <= 2), i); end
      checks++; if (empty !== (i == 0)) begin errors++; $display("FAIL drain_empty: got %b expected %b at %0d", empty, (i == 0), i); end
      checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL drain_rd_valid: got %b expected 1", rd_valid); end
    end
    set_in(1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if ({wr_en, rd_en} !== 2'b10) begin errors++; $display("FAIL empty_rw_strobes: got %b expected 10", {wr_en, rd_en}); end
    tick();
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL empty_rw_udf: got %b expected 1", underflow); end
    checks++; if (count !== CW'(1)) begin errors++; $display("FAIL empty_rw_count: got %0d expected 1", count); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL empty_rw_empty: got %b expected 0", empty); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL empty_rw_rd_valid: got %b expected 0", rd_valid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL empty_rw_ovf_held: got %b expected 1", overflow); end
  endtask

  task automatic test_stream();
    logic [PW-1:0] prev;
    logic          saw_wrap;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    checks++; if (count !== CW'(4)) begin errors++; $display("FAIL stream_pre_count: got %0d expected 4", count); end
    saw_wrap = 1'b0;
    prev = rd_addr;
    for (int i = 0; i < 20; i++) begin
      set_in(1'b1, 1'b1, 1'b0, 1'b0);
      checks++; if ({wr_en, rd_en} !== 2'b11) begin errors++; $display("FAIL stream_strobes: got %b expected 11", {wr_en, rd_en}); end
      tick();
      checks++; if (count !== CW'(4)) begin errors++; $display("FAIL stream_count: got %0d expected 4", count); end
      checks++; if (wr_addr !== PW'(m_wp % DEP)) begin errors++; $display("FAIL stream_wr_addr: got %0d expected %0d", wr_addr, m_wp % DEP); end
      checks++; if (rd_addr !== PW'(m_rp % DEP)) begin errors++; $display("FAIL stream_rd_addr: got %0d expected %0d", rd_addr, m_rp % DEP); end
      checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL stream_rd_valid: got %b expected 1", rd_valid); end
      if (prev == PW'(7) && rd_addr == '0) saw_wrap = 1'b1;
      prev = rd_addr;
    end
    checks++; if (saw_wrap !== 1'b1) begin errors++; $display("FAIL stream_wrap: got %b expected 1", saw_wrap); end
  endtask

  task automatic test_flush();
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checks++; if (count !== CW'(5)) begin errors++; $display("FAIL flush_pre_count: got %0d expected 5", count); end
    set_in(1'b1, 1'b1, 1'b1, 1'b0);
    checks++; if ({wr_en, rd_en} !== 2'b00) begin errors++; $display("FAIL flush_strobes: got %b expected 00", {wr_en, rd_en}); end
    tick();
    checks++; if (count !== '0) begin errors++; $display("FAIL flush_count: got %0d expected 0", count); end
    checks++; if ({full, empty, almost_full, almost_empty} !== 4'b0101) begin
      errors++; $display("FAIL flush_flags: got %b expected 0101", {full, empty, almost_full, almost_empty});
    end
    checks++; if ({wr_addr, rd_addr} !== '0) begin errors++; $display("FAIL flush_addr: got %0d/%0d expected 0/0", wr_addr, rd_addr); end
    checks++; if ({overflow, underflow} !== 2'b11) begin errors++; $display("FAIL flush_err_kept: got %b expected 11", {overflow, underflow}); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL flush_rd_valid: got %b expected 0", rd_valid); end
  endtask

  task automatic test_clr_err();
    set_in(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL clr_err: got %b expected 00", {overflow, underflow}); end
    set_in(1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL clr_set_wins: got %b expected 1", underflow); end
    set_in(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    checks++; if (underflow !== m_udf) begin errors++; $display("FAIL clr_again: got %b expected %b", underflow, m_udf); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    set_in(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    checks++; if ({count, rd_valid} !== {CW'(3), 1'b1}) begin
      errors++; $display("FAIL mid_pre: got count %0d rd_valid %b expected 3/1", count, rd_valid);
    end
    set_in(1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    checks++; if (count !== '0) begin errors++; $display("FAIL mid_rst_count: got %0d expected 0", count); end
    checks++; if ({empty, almost_empty, full} !== 3'b110) begin errors++; $display("FAIL mid_rst_flags: got %b expected 110", {empty, almost_empty, full}); end
    checks++; if ({rd_valid, rd_en} !== 2'b00) begin errors++; $display("FAIL mid_rst_rd: got %b expected 00", {rd_valid, rd_en}); end
    model_reset();
    @(posedge clk); #1;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_inflight: got %b expected 0", rd_valid); end
    rst = 1'b0; rd_req = 1'b0;
    set_in(1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL mid_new_err: got %b expected 1", underflow); end
    checks++; if ({wr_addr, rd_addr} !== '0) begin errors++; $display("FAIL mid_addr: got %0d/%0d expected 0/0", wr_addr, rd_addr); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fill();
    test_full_rw();
    test_drain_empty_rw();
    test_stream();
    test_flush();
    test_clr_err();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
